cordic_rr_scheduler: RTL and testbench

- Shares one pipelined vectoring/rotation CORDIC core (module sublime) between two requesters.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Issues at most one operation per clock into the core.
- Tracks the owner of every in-flight operation in a tag pipeline that runs alongside the core. Each result returns to its owner as a one-cycle pulse.

---
 rtl/cordic_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_cordic_rr_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rr_scheduler.sv
// cordic_rr_scheduler
// Shares one pipelined CORDIC core (sublime) between two requesters.
// Arbitration is round-robin over a valid/ready handshake. At most one
// operation is issued per clock. A tag pipeline runs alongside the core and
// records the owner of every in-flight operation, so each result is routed
// back to its owner as a one-cycle pulse.
//
// Ports:
//   clock, reset_n              rising-edge clock, async active-low reset
//   enable                      0 blocks new grants; in-flight ops still drain
//   reqK_valid/ready            request handshake for requester K (0/1)
//   reqK_angle/xin/yin          operands for requester K
//   cordic_angle/xin/yin        registered operands to the core
//   cordic_xout/yout            results from the core, LATENCY edges after grant
//   rspK_valid/xout/yout        one-cycle result pulse and data for requester K
//   busy                        at least one operation in flight
module cordic_rr_scheduler #(
  parameter int XY_SIZE = 8,
  parameter int LATENCY = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [31:0]        req0_angle,
  input  logic [XY_SIZE-1:0] req0_xin,
  input  logic [XY_SIZE-1:0] req0_yin,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [31:0]        req1_angle,
  input  logic [XY_SIZE-1:0] req1_xin,
  input  logic [XY_SIZE-1:0] req1_yin,
  output logic [31:0]        cordic_angle,
  output logic [XY_SIZE-1:0] cordic_xin,
  output logic [XY_SIZE-1:0] cordic_yin,
  input  logic [XY_SIZE-1:0] cordic_xout,
  input  logic [XY_SIZE-1:0] cordic_yout,
  output logic               rsp0_valid,
  output logic [XY_SIZE-1:0] rsp0_xout,
  output logic [XY_SIZE-1:0] rsp0_yout,
  output logic               rsp1_valid,
  output logic [XY_SIZE-1:0] rsp1_xout,
  output logic [XY_SIZE-1:0] rsp1_yout,
  output logic               busy
);

  // Requester that won the most recent grant; reset to 1 so port 0 wins first.
  logic               last_grant;
  logic               grant0;
  logic               grant1;
  logic               xfer0;
  logic               xfer1;
  // Slot 0 is written at the grant edge; slot LATENCY-1 lines up with the
  // core result that is sampled on the following edge.
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_owner;
  logic               out_valid;
  logic               out_owner;

  // Round-robin arbiter; ready is gated in reset and never feeds back on itself.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n && enable) begin
      if (req0_valid && req1_valid) begin
        if (last_grant) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer0      = req0_valid & grant0;
  assign xfer1      = req1_valid & grant1;

  assign out_valid  = tag_valid[LATENCY-1];
  assign out_owner  = tag_owner[LATENCY-1];
  assign busy       = |tag_valid;

  // Operand register to the core and round-robin history; both hold with no transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cordic_angle <= 32'h0000_0000;
      cordic_xin   <= {XY_SIZE{1'b0}};
      cordic_yin   <= {XY_SIZE{1'b0}};
      last_grant   <= 1'b1;
    end else if (xfer0) begin
      cordic_angle <= req0_angle;
      cordic_xin   <= req0_xin;
      cordic_yin   <= req0_yin;
      last_grant   <= 1'b0;
    end else if (xfer1) begin
      cordic_angle <= req1_angle;
      cordic_xin   <= req1_xin;
      cordic_yin   <= req1_yin;
      last_grant   <= 1'b1;
    end
  end

  // Tag pipeline; shifts every edge because the core itself never stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= {LATENCY{1'b0}};
      tag_owner <= {LATENCY{1'b0}};
    end else begin
      tag_valid <= {tag_valid[LATENCY-2:0], xfer0 | xfer1};
      tag_owner <= {tag_owner[LATENCY-2:0], xfer1};
    end
  end

  // Response routing; the port not receiving a result keeps its last data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_valid <= 1'b0;
      rsp0_xout  <= {XY_SIZE{1'b0}};
      rsp0_yout  <= {XY_SIZE{1'b0}};
      rsp1_valid <= 1'b0;
      rsp1_xout  <= {XY_SIZE{1'b0}};
      rsp1_yout  <= {XY_SIZE{1'b0}};
    end else begin
      rsp0_valid <= out_valid & ~out_owner;
      rsp1_valid <= out_valid & out_owner;
      if (out_valid && !out_owner) begin
        rsp0_xout <= cordic_xout;
        rsp0_yout <= cordic_yout;
      end
      if (out_valid && out_owner) begin
        rsp1_xout <= cordic_xout;
        rsp1_yout <= cordic_yout;
      end
    end
  end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler. Two instances share one set of request
// inputs: one built with LATENCY=8 (a_*) and one with LATENCY=2 (b_*).
// Each has its own stand-in core: a delay line of LATENCY-1 registers
// around core_fn. Stimulus pushes expected results into per-port queues;
// a monitor pops and compares on every response pulse.
module tb_cordic_rr_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_angle = 32'h0, req1_angle = 32'h0;
  logic [7:0]  req0_xin = 8'h0, req0_yin = 8'h0, req1_xin = 8'h0, req1_yin = 8'h0;

  logic        a_r0, a_r1, a_v0, a_v1, a_busy;
  logic [31:0] a_ang;
  logic [7:0]  a_cx, a_cy, a_xo, a_yo, a_x0, a_y0, a_x1, a_y1;
  logic        b_r0, b_r1, b_v0, b_v1, b_busy;
  logic [31:0] b_ang;
  logic [7:0]  b_cx, b_cy, b_xo, b_yo, b_x0, b_y0, b_x1, b_y1;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] core_fn(input logic [31:0] a, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] xo, yo;
    xo = x + a[31:24];
    yo = y ^ a[23:16];
    return {xo, yo};
  endfunction

  // Stand-in cores: operands registered at the grant edge, result ready
  // just before edge grant+LATENCY.
  logic [15:0] a_pipe [0:6];
  logic [15:0] b_pipe;
  always @(posedge clock) begin
    a_pipe[0] <= core_fn(a_ang, a_cx, a_cy);
    for (int i = 1; i < 7; i++) a_pipe[i] <= a_pipe[i-1];
    b_pipe <= core_fn(b_ang, b_cx, b_cy);
  end
  assign a_xo = a_pipe[6][15:8];
  assign a_yo = a_pipe[6][7:0];
  assign b_xo = b_pipe[15:8];
  assign b_yo = b_pipe[7:0];

  cordic_rr_scheduler #(.XY_SIZE(8), .LATENCY(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .req0_valid(req0_valid), .req0_ready(a_r0), .req0_angle(req0_angle), .req0_xin(req0_xin), .req0_yin(req0_yin),
    .req1_valid(req1_valid), .req1_ready(a_r1), .req1_angle(req1_angle), .req1_xin(req1_xin), .req1_yin(req1_yin),
    .cordic_angle(a_ang), .cordic_xin(a_cx), .cordic_yin(a_cy), .cordic_xout(a_xo), .cordic_yout(a_yo),
    .rsp0_valid(a_v0), .rsp0_xout(a_x0), .rsp0_yout(a_y0),
    .rsp1_valid(a_v1), .rsp1_xout(a_x1), .rsp1_yout(a_y1), .busy(a_busy));

  cordic_rr_scheduler #(.XY_SIZE(8), .LATENCY(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .req0_valid(req0_valid), .req0_ready(b_r0), .req0_angle(req0_angle), .req0_xin(req0_xin), .req0_yin(req0_yin),
    .req1_valid(req1_valid), .req1_ready(b_r1), .req1_angle(req1_angle), .req1_xin(req1_xin), .req1_yin(req1_yin),
    .cordic_angle(b_ang), .cordic_xin(b_cx), .cordic_yin(b_cy), .cordic_xout(b_xo), .cordic_yout(b_yo),
    .rsp0_valid(b_v0), .rsp0_xout(b_x0), .rsp0_yout(b_y0),
    .rsp1_valid(b_v1), .rsp1_xout(b_x1), .rsp1_yout(b_y1), .busy(b_busy));

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int         due;
  } exp_t;

  exp_t q_a0[$], q_a1[$], q_b0[$], q_b1[$];
  bit   gedge [0:1023];
  int   n_vec = 0, n_err = 0, seq = 0;
  logic [31:0] ea = 32'h0;
  logic [7:0]  ex = 8'h0, ey = 8'h0;
  bit          ovr = 1'b0;
  logic [31:0] ovr_a = 32'h0;
  logic [7:0]  ovr_x = 8'h0, ovr_y = 8'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_busy(input int lat);
    bit b;
    b = 1'b0;
    for (int e = cyc - lat + 1; e <= cyc; e++)
      if (e >= 0 && e < 1024) b = b | gedge[e];
    return b;
  endfunction

  task automatic push(input int port, input logic [31:0] a, input logic [7:0] x, input logic [7:0] y);
    exp_t ea8, eb2;
    logic [15:0] r;
    r = core_fn(a, x, y);
    ea8.x = r[15:8]; ea8.y = r[7:0]; ea8.due = cyc + 1 + 8;
    eb2.x = r[15:8]; eb2.y = r[7:0]; eb2.due = cyc + 1 + 2;
    if (port == 0) begin
      q_a0.push_back(ea8); q_b0.push_back(eb2);
    end else begin
      q_a1.push_back(ea8); q_b1.push_back(eb2);
    end
  endtask

  task automatic pop(input int id);
    case (id)
      0: void'(q_a0.pop_front());
      1: void'(q_a1.pop_front());
      2: void'(q_b0.pop_front());
      default: void'(q_b1.pop_front());
    endcase
  endtask

  task automatic mon(input int id, input logic v, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    bit   have;
    have = 1'b0;
    e.x = 8'h0; e.y = 8'h0; e.due = 0;
    case (id)
      0: if (q_a0.size() > 0) begin e = q_a0[0]; have = 1'b1; end
      1: if (q_a1.size() > 0) begin e = q_a1[0]; have = 1'b1; end
      2: if (q_b0.size() > 0) begin e = q_b0[0]; have = 1'b1; end
      default: if (q_b1.size() > 0) begin e = q_b1[0]; have = 1'b1; end
    endcase
    if (v) begin
      if (!have) begin
        n_vec++; n_err++;
        $display("FAIL rsp_unexpected[%0d]: got pulse, expected none (edge %0d)", id, cyc);
      end else begin
        pop(id);
        chk($sformatf("rsp_x[%0d]", id), x, e.x);
        chk($sformatf("rsp_y[%0d]", id), y, e.y);
        chk($sformatf("rsp_edge[%0d]", id), cyc, e.due);
      end
    end else if (have && e.due <= cyc) begin
      n_vec++; n_err++;
      $display("FAIL rsp_missing[%0d]: got no pulse, expected one at edge %0d (edge %0d)", id, e.due, cyc);
      pop(id);
    end
  endtask

  // Monitor: compares every response pulse and the busy flag once per cycle.
  initial begin
    forever begin
      @(negedge clock);
      mon(0, a_v0, a_x0, a_y0);
      mon(1, a_v1, a_x1, a_y1);
      mon(2, b_v0, b_x0, b_y0);
      mon(3, b_v1, b_x1, b_y1);
      chk("busy_l8", a_busy, exp_busy(8));
      chk("busy_l2", b_busy, exp_busy(2));
    end
  end

  // One cycle of stimulus: drive, check ready, record grant, check operands.
  task automatic step(input logic v0, input logic v1, input logic en, input logic r0, input logic r1);
    logic [31:0] a0, a1;
    logic [7:0]  x0, y0, x1, y1, s;
    seq++;
    s  = seq[7:0];
    a0 = {s, 8'h11, s ^ 8'h5A, 8'h00};
    x0 = s + 8'd10;
    y0 = 8'd200 - s;
    if (ovr) begin
      a0 = ovr_a; x0 = ovr_x; y0 = ovr_y;
    end
    a1 = {s ^ 8'hF0, 8'h22, s, 8'h01};
    x1 = s + 8'd90;
    y1 = s ^ 8'h3C;
    enable = en;
    req0_valid = v0; req0_angle = a0; req0_xin = x0; req0_yin = y0;
    req1_valid = v1; req1_angle = a1; req1_xin = x1; req1_yin = y1;
    #1;
    chk("ready0_l8", a_r0, r0);
    chk("ready1_l8", a_r1, r1);
    chk("ready0_l2", b_r0, r0);
    chk("ready1_l2", b_r1, r1);
    if (v0 && r0) begin
      push(0, a0, x0, y0);
      ea = a0; ex = x0; ey = y0;
      gedge[cyc+1] = 1'b1;
    end else if (v1 && r1) begin
      push(1, a1, x1, y1);
      ea = a1; ex = x1; ey = y1;
      gedge[cyc+1] = 1'b1;
    end
    @(negedge clock);
    chk("cordic_angle_l8", a_ang, ea);
    chk("cordic_xin_l8", a_cx, ex);
    chk("cordic_yin_l8", a_cy, ey);
    chk("cordic_angle_l2", b_ang, ea);
    chk("cordic_xin_l2", b_cx, ex);
    chk("cordic_yin_l2", b_cy, ey);
  endtask

  task automatic reset_checks();
    chk("rst_ready0_l8", a_r0, 1'b0);
    chk("rst_ready1_l8", a_r1, 1'b0);
    chk("rst_ready0_l2", b_r0, 1'b0);
    chk("rst_ready1_l2", b_r1, 1'b0);
    chk("rst_rsp_valid_l8", {a_v0, a_v1}, 2'b00);
    chk("rst_rsp_valid_l2", {b_v0, b_v1}, 2'b00);
    chk("rst_rsp_data_l8", {a_x0, a_y0, a_x1, a_y1}, 32'h0);
    chk("rst_rsp_data_l2", {b_x0, b_y0, b_x1, b_y1}, 32'h0);
    chk("rst_busy", {a_busy, b_busy}, 2'b00);
    chk("rst_cordic_l8", {a_ang[7:0], a_cx, a_cy}, 24'h0);
    chk("rst_cordic_l2", {b_ang[7:0], b_cx, b_cy}, 24'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) gedge[i] = 1'b0;
    // Reset state with both requesters already valid.
    reset_n = 1'b0; enable = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    reset_checks();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Contention from reset: 0,1,0,1,0,1.
    repeat (3) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Single operation on req0: core sees xin=77, result x=77+0x20, y=0.
    ovr = 1'b1; ovr_a = 32'h2000_0000; ovr_x = 8'd77; ovr_y = 8'd0;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    ovr = 1'b0;
    chk("single_cordic_xin", a_cx, 8'd77);
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Streamer on req1, then req0 joins and wins immediately.
    repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    // Enable low with both valid: no grants, in-flight results drain.
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Last grant was port 1, so port 0 resumes first.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-flight: three req0 grants, then async reset for two cycles.
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #3;
    reset_n = 1'b0;
    q_a0.delete(); q_a1.delete(); q_b0.delete(); q_b1.delete();
    for (int i = 0; i < 1024; i++) gedge[i] = 1'b0;
    ea = 32'h0; ex = 8'h0; ey = 8'h0;
    #1;
    reset_checks();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    // Last grant before reset was port 0; reset restores priority to port 0.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    chk("pending_a0", q_a0.size(), 0);
    chk("pending_a1", q_a1.size(), 0);
    chk("pending_b0", q_b0.size(), 0);
    chk("pending_b1", q_b1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
